max_pool_2x2_stream: RTL
========================

Name: max_pool_2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the per-filter bias-add/ReLU stage.
- Consumes one IEEE-754 single-precision activation per valid cycle, in raster order (row-major, one feature map per frame).
- Emits one pooled value per 2x2 window, in raster order of the pooled map.
- Uses a half-width line buffer, so a full input row is never stored.

Parameters:
- DATA_WIDTH, 32, activation word width (IEEE-754 single precision).
- IMG_WIDTH, 32, input feature-map width in pixels; must be even and >= 2.
- IMG_HEIGHT, 32, input feature-map height in pixels; must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  activation from the bias-add/ReLU stage (its data_out).
- valid_in  input  1  data_in is valid this cycle (that stage's valid_out).
- data_out  output  DATA_WIDTH  pooled maximum of one 2x2 window.
- valid_out  output  1  one-cycle pulse per pooled result.
- last_out  output  1  high together with valid_out on the final pooled value of a frame.

Behaviour:
- Clock and reset: single clock, clk; reset is synchronous and active-high, on rst.
- Reset values: data_out=0, valid_out=0, last_out=0, col=0, row=0, pair_reg=0. Line-buffer contents are not reset; each entry is written on an even row before it is read on the following odd row.
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, both $clog2-sized.
  - Both advance only on valid_in=1.
  - col wraps to 0 and row increments together.
  - At row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, both wrap to 0 (frame wrap); the next frame starts with no idle cycle.
- Gaps: valid_in=0 freezes all state. Bubbles of any length, anywhere in the frame, are legal and change no result.
- Per accepted pixel:
  - even col: pair_reg <= data_in.
  - odd col, even row: linebuf[col>>1] <= max(pair_reg, data_in).
  - odd col, odd row: data_out <= max(linebuf[col>>1], max(pair_reg, data_in)); valid_out <= 1.
  - last_out <= 1 additionally when row=IMG_HEIGHT-1 and col=IMG_WIDTH-1.
- Latency: valid_out rises exactly 1 clk after the cycle that accepts the bottom-right pixel of a window.
- Outputs:
  - valid_out and last_out are single-cycle pulses.
  - data_out holds its last value while valid_out=0.
  - No backpressure; the downstream stage must accept every pulse.
- Max rule (fp_max):
  - Sign-magnitude IEEE compare.
  - If both signs are 0: unsigned compare of the bit patterns.
  - If the signs differ: the positive operand wins.
  - If both are negative: the smaller magnitude wins.
  - Ties, including +0 vs -0: return operand a.
  - NaN/Inf need no special handling (upstream ReLU output is finite and >= 0).
- Throughput: one input per cycle, sustained.
- Reset mid-frame: all counters and outputs return to reset values on the next edge. Any partial window is discarded, and the next accepted pixel is treated as (row 0, col 0).
- rst and valid_in high together: rst wins and the pixel is dropped.
- Line buffer: IMG_WIDTH/2 entries x DATA_WIDTH, one write or one read per cycle; register or distributed RAM.
- Elaboration check: $error if IMG_WIDTH or IMG_HEIGHT is odd or < 2.

Decomposition:
- Shared package pool_pkg:
  - DATA_WIDTH default.
  - FP constants FP_ZERO=32'h00000000 and FP_NEG_ZERO=32'h80000000.
  - Sign/exponent/mantissa field-position localparams.
- Sub-module fp_max: purely combinational, ports a, b -> res. It is instantiated twice (horizontal max and vertical max).

Test Plan:
- 4x4 frame, pixels p[r][c] = 1.0 * (4r + c + 1) (first row 0x3F800000, 0x40000000, 0x40400000, 0x40800000, ...), valid every cycle -> 4 pulses 6.0, 8.0, 14.0, 16.0 (0x40C00000, 0x41000000, 0x41600000, 0x41800000). Each pulse comes 1 cycle after pixels (1,1), (1,3), (3,1), (3,3); last_out only on 16.0.
- Same frame with valid_in toggling 1,0,1,0 and random 0-5 cycle bubbles -> identical values and order; each pulse 1 cycle after its triggering accepted pixel.
- Window {0.5, 0x00000000, 0x80000000, 0.5} in the top-left of a 2x2 frame -> 0x3F000000. Window {-1.0, -2.0, -3.0, -0.5} -> 0xBF000000 (-0.5). Window {0x00000000, 0x80000000, 0x80000000, 0x80000000} -> 0x00000000.
- Two back-to-back 4x4 frames with no gap -> 8 pulses; last_out on the 4th and 8th; second-frame values unaffected by the first frame's line-buffer contents.
- Assert rst for 1 cycle after 6 pixels of a 4x4 frame, then a full frame -> no output from the aborted frame; exactly 4 correct pulses afterwards.
- rst held with valid_in=1 for 3 cycles -> valid_out=0, data_out=0, and counters remain 0 throughout.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants for the 2x2 max-pooling stage: word width, signed-zero
// patterns and IEEE-754 single-precision field positions.
package pool_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

endpackage

// File: rtl/fp_max.sv
// Combinational sign-magnitude maximum of two IEEE-754 words.
// Equal values (including +0 against -0) return operand a.
module fp_max
  import pool_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res
);

  logic         sa, sb;
  logic [W-2:0] ma, mb;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ma = a[W-2:0];
  assign mb = b[W-2:0];

  always_comb begin
    res = a;
    if (sa != sb) begin
      // Opposite signs: only the two zeros compare equal.
      if ((ma != '0) || (mb != '0)) begin
        res = sa ? b : a;
      end
    end else if (!sa) begin
      res = (mb > ma) ? b : a;
    end else begin
      res = (mb < ma) ? b : a;
    end
  end

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 / stride-2 max pool over a raster-order frame, one pixel per valid cycle.
// Row pairs are folded into a half-width line buffer; results appear one cycle after the window's last pixel.
module max_pool_2x2_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = pool_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  last_out
);

  localparam int CW       = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW       = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  generate
    if ((IMG_WIDTH % 2 != 0) || (IMG_WIDTH < 2) ||
        (IMG_HEIGHT % 2 != 0) || (IMG_HEIGHT < 2)) begin : g_bad_dims
      $error("max_pool_2x2_stream: IMG_WIDTH and IMG_HEIGHT must be even and >= 2");
    end
  endgenerate

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  last_out_q, last_out_d;

  logic [DATA_WIDTH-1:0] linebuf_q [LB_DEPTH];
  logic [LBW-1:0]        lb_idx;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic                  lb_we;

  logic [DATA_WIDTH-1:0] h_max, v_max;
  logic                  col_end, row_end;

  assign col_end = (col_q == CW'(IMG_WIDTH - 1));
  assign row_end = (row_q == RW'(IMG_HEIGHT - 1));
  assign lb_idx  = LBW'(col_q >> 1);
  assign lb_rd   = linebuf_q[lb_idx];

  fp_max #(.W(DATA_WIDTH)) u_hmax (
    .a   (pair_q),
    .b   (data_in),
    .res (h_max)
  );

  fp_max #(.W(DATA_WIDTH)) u_vmax (
    .a   (lb_rd),
    .b   (h_max),
    .res (v_max)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    last_out_d  = 1'b0;
    lb_we       = 1'b0;

    if (valid_in) begin
      // Even column opens a horizontal pair; odd column closes it.
      if (!col_q[0]) begin
        pair_d = data_in;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        data_out_d  = v_max;
        valid_out_d = 1'b1;
        last_out_d  = col_end && row_end;
      end

      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
    end
  end

  // Entries are always written on an even row before being read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && lb_we) begin
      linebuf_q[lb_idx] <= h_max;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;

endmodule
